// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus delay-line sequencer: tap width, FSM states,
// the captured config request and the window-centre helper.
package hyperbus_pkg;

    localparam int unsigned DelayWidth = 4;
    localparam int unsigned LenWidth   = DelayWidth + 1;

    typedef logic [DelayWidth-1:0] tap_t;
    typedef logic [LenWidth-1:0]   len_t;

    typedef enum logic [2:0] {
        StIdle,
        StWaitIdle,
        StSettle,
        StProbe,
        StNext,
        StDone
    } delay_ctrl_state_e;

    typedef struct packed {
        logic sel;
        logic train;
        tap_t delay;
    } delay_req_t;

    // Lower-middle tap of a window, so even-length windows bias toward earlier taps.
    function automatic tap_t window_centre(input tap_t start, input len_t len);
        len_t half;
        half = (len - LenWidth'(1)) >> 1;
        return start + half[DelayWidth-1:0];
    endfunction

endpackage

// File: rtl/hyperbus_delay_window.sv
// Tracks the longest run of passing taps seen during a sweep; earliest run wins ties.
module hyperbus_delay_window
    import hyperbus_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic sample_i,
    input  logic pass_i,
    input  tap_t tap_i,
    input  logic close_i,
    output tap_t best_start_o,
    output len_t best_len_o
);

    tap_t run_start_q, best_start_q;
    len_t run_len_q, best_len_q;
    logic run_longer;

    assign run_longer = run_len_q > best_len_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else if (clear_i) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else if (sample_i) begin
            if (pass_i) begin
                if (run_len_q == '0) run_start_q <= tap_i;
                run_len_q <= run_len_q + LenWidth'(1);
            end else begin
                if (run_longer) begin
                    best_start_q <= run_start_q;
                    best_len_q   <= run_len_q;
                end
                run_len_q <= '0;
            end
        end else if (close_i) begin
            if (run_longer) begin
                best_start_q <= run_start_q;
                best_len_q   <= run_len_q;
            end
            run_len_q <= '0;
        end
    end

    // While closing, expose the post-close view so the caller can use it this cycle.
    assign best_start_o = (close_i && run_longer) ? run_start_q : best_start_q;
    assign best_len_o   = (close_i && run_longer) ? run_len_q   : best_len_q;

endmodule

// File: rtl/hyperbus_delay_ctrl.sv
// Sequences RX/TX delay-line taps: direct writes and 16-tap training sweeps,
// applying taps only while the PHY is idle and settling before ack/probe.
module hyperbus_delay_ctrl
    import hyperbus_pkg::*;
#(
    parameter int unsigned           NumSettleCycles = 8,
    parameter logic [DelayWidth-1:0] RstDelayRx      = 4'd8,
    parameter logic [DelayWidth-1:0] RstDelayTx      = 4'd8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic                  cfg_sel_i,
    input  logic                  cfg_train_i,
    input  logic [DelayWidth-1:0] cfg_delay_i,
    input  logic                  phy_idle_i,
    output logic [DelayWidth-1:0] delay_rx_o,
    output logic [DelayWidth-1:0] delay_tx_o,
    output logic                  probe_req_o,
    input  logic                  probe_ack_i,
    input  logic                  probe_pass_i,
    output logic                  done_o,
    output logic                  train_fail_o,
    output logic [DelayWidth-1:0] result_o
);

    localparam int unsigned CntW = $clog2(NumSettleCycles + 1);
    localparam tap_t        LastTap = '1;

    delay_ctrl_state_e state_q;
    delay_req_t        req_in;
    logic              sel_q, train_q, final_q, fail_q;
    tap_t              pend_q, saved_q, tap_q, applied_q;
    tap_t              rx_q, tx_q, result_q;
    logic [CntW-1:0]   settle_q;
    logic              ready_q, probe_q, done_q, train_fail_q;

    logic win_clear, win_sample, win_close;
    tap_t best_start;
    len_t best_len;

    assign req_in = '{sel: cfg_sel_i, train: cfg_train_i, delay: cfg_delay_i};

    assign win_clear  = (state_q == StIdle) && cfg_valid_i && cfg_train_i;
    assign win_sample = (state_q == StProbe) && probe_ack_i;
    assign win_close  = (state_q == StNext) && (tap_q == LastTap);

    hyperbus_delay_window u_window (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (win_clear),
        .sample_i    (win_sample),
        .pass_i      (probe_pass_i),
        .tap_i       (tap_q),
        .close_i     (win_close),
        .best_start_o(best_start),
        .best_len_o  (best_len)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            sel_q        <= 1'b0;
            train_q      <= 1'b0;
            final_q      <= 1'b0;
            fail_q       <= 1'b0;
            pend_q       <= '0;
            saved_q      <= '0;
            tap_q        <= '0;
            applied_q    <= '0;
            rx_q         <= RstDelayRx;
            tx_q         <= RstDelayTx;
            result_q     <= '0;
            settle_q     <= '0;
            ready_q      <= 1'b1;
            probe_q      <= 1'b0;
            done_q       <= 1'b0;
            train_fail_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            train_fail_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cfg_valid_i && ready_q) begin
                        sel_q   <= req_in.sel;
                        train_q <= req_in.train;
                        final_q <= 1'b0;
                        fail_q  <= 1'b0;
                        tap_q   <= '0;
                        saved_q <= req_in.sel ? tx_q : rx_q;
                        pend_q  <= req_in.train ? '0 : req_in.delay;
                        ready_q <= 1'b0;
                        state_q <= StWaitIdle;
                    end
                end
                StWaitIdle: begin
                    if (phy_idle_i) begin
                        if (sel_q) tx_q <= pend_q;
                        else       rx_q <= pend_q;
                        applied_q <= pend_q;
                        settle_q  <= '0;
                        state_q   <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_q == CntW'(NumSettleCycles - 1)) begin
                        if (!train_q || final_q) begin
                            done_q       <= 1'b1;
                            train_fail_q <= fail_q;
                            result_q     <= applied_q;
                            state_q      <= StDone;
                        end else begin
                            probe_q <= 1'b1;
                            state_q <= StProbe;
                        end
                    end else begin
                        settle_q <= settle_q + CntW'(1);
                    end
                end
                StProbe: begin
                    if (probe_ack_i) begin
                        probe_q <= 1'b0;
                        state_q <= StNext;
                    end
                end
                StNext: begin
                    if (tap_q == LastTap) begin
                        final_q <= 1'b1;
                        if (best_len == '0) begin
                            pend_q <= saved_q;
                            fail_q <= 1'b1;
                        end else begin
                            pend_q <= window_centre(best_start, best_len);
                        end
                    end else begin
                        tap_q  <= tap_q + DelayWidth'(1);
                        pend_q <= tap_q + DelayWidth'(1);
                    end
                    state_q <= StWaitIdle;
                end
                StDone: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    ready_q <= 1'b1;
                    probe_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cfg_ready_o  = ready_q;
    assign delay_rx_o   = rx_q;
    assign delay_tx_o   = tx_q;
    assign probe_req_o  = probe_q;
    assign done_o       = done_q;
    assign train_fail_o = train_fail_q;
    assign result_o     = result_q;

endmodule

// File: tb/tb_hyperbus_delay_ctrl.sv
// Directed bench for hyperbus_delay_ctrl: direct writes, idle gating, training sweeps, async reset.
module tb_hyperbus_delay_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cfg_valid_i, cfg_sel_i, cfg_train_i;
    logic [3:0] cfg_delay_i;
    logic       cfg_ready_o;
    logic       phy_idle_i;
    logic [3:0] delay_rx_o, delay_tx_o, result_o;
    logic       probe_req_o, probe_ack_i, probe_pass_i;
    logic       done_o, train_fail_o;

    logic [15:0] pass_mask;
    int          probe_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          base;

    always #5 clk_i = ~clk_i;

    hyperbus_delay_ctrl #(
        .NumSettleCycles(8),
        .RstDelayRx     (4'd8),
        .RstDelayTx     (4'd8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_sel_i   (cfg_sel_i),
        .cfg_train_i (cfg_train_i),
        .cfg_delay_i (cfg_delay_i),
        .phy_idle_i  (phy_idle_i),
        .delay_rx_o  (delay_rx_o),
        .delay_tx_o  (delay_tx_o),
        .probe_req_o (probe_req_o),
        .probe_ack_i (probe_ack_i),
        .probe_pass_i(probe_pass_i),
        .done_o      (done_o),
        .train_fail_o(train_fail_o),
        .result_o    (result_o)
    );

    // PHY model: acks a probe in its first cycle; result comes from the mask at the RX tap.
    always @(negedge clk_i) begin
        probe_ack_i  = probe_req_o;
        probe_pass_i = probe_req_o ? pass_mask[delay_rx_o] : 1'b0;
    end

    always @(posedge clk_i) begin
        if (probe_req_o && probe_ack_i) probe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send(input logic sel, input logic train, input logic [3:0] dly);
        check("ready_before_req", cfg_ready_o, 1);
        cfg_valid_i = 1'b1;
        cfg_sel_i   = sel;
        cfg_train_i = train;
        cfg_delay_i = dly;
        step(1);
        cfg_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_o !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        check(tag, done_o, 1);
    endtask

    initial begin
        rst_ni      = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_sel_i   = 1'b0;
        cfg_train_i = 1'b0;
        cfg_delay_i = 4'd0;
        phy_idle_i  = 1'b1;
        pass_mask   = 16'h0000;
        step(2);
        check("rst_rx", delay_rx_o, 8);
        check("rst_tx", delay_tx_o, 8);
        check("rst_ready", cfg_ready_o, 1);
        check("rst_done", done_o, 0);
        check("rst_probe", probe_req_o, 0);
        check("rst_result", result_o, 0);
        rst_ni = 1'b1;
        step(1);

        // Direct TX write, PHY idle: handshake cycle 0, tap at 2, done at 10.
        send(1'b1, 1'b0, 4'd3);
        check("tx_wait_idle_old", delay_tx_o, 8);
        step(1);
        check("tx_applied", delay_tx_o, 3);
        check("tx_no_early_done", done_o, 0);
        step(7);
        check("tx_done_not_yet", done_o, 0);
        step(1);
        check("tx_done", done_o, 1);
        check("tx_result", result_o, 3);
        check("tx_fail_flag", train_fail_o, 0);
        check("tx_rx_unchanged", delay_rx_o, 8);
        step(1);
        check("tx_done_pulse", done_o, 0);
        check("tx_ready_again", cfg_ready_o, 1);
        check("tx_result_hold", result_o, 3);

        // Direct RX write while PHY busy for 20 cycles.
        phy_idle_i = 1'b0;
        send(1'b0, 1'b0, 4'd5);
        for (int i = 0; i < 20; i++) begin
            check("busy_rx_hold", delay_rx_o, 8);
            step(1);
        end
        phy_idle_i = 1'b1;
        step(1);
        check("busy_rx_applied", delay_rx_o, 5);
        wait_done("busy_done", 50);
        check("busy_result", result_o, 5);
        step(1);

        // RX training: taps 3..9 and 12..13 pass -> centre of 3..9 is 6.
        pass_mask = 16'h33F8;
        base = probe_cnt;
        send(1'b0, 1'b1, 4'd0);
        wait_done("tr1_done", 1000);
        check("tr1_rx", delay_rx_o, 6);
        check("tr1_result", result_o, 6);
        check("tr1_fail", train_fail_o, 0);
        check("tr1_probes", probe_cnt - base, 16);
        check("tr1_tx_untouched", delay_tx_o, 3);
        step(1);

        // Tie: 2..4 and 10..12 -> earliest run wins, centre 3.
        pass_mask = 16'h1C1C;
        send(1'b0, 1'b1, 4'd0);
        wait_done("tr2_done", 1000);
        check("tr2_rx", delay_rx_o, 3);
        check("tr2_result", result_o, 3);
        check("tr2_fail", train_fail_o, 0);
        step(1);

        // All fail: RX restored to prior tap 3, fail flagged with done.
        pass_mask = 16'h0000;
        send(1'b0, 1'b1, 4'd0);
        wait_done("tr3_done", 1000);
        check("tr3_rx_restored", delay_rx_o, 3);
        check("tr3_result", result_o, 3);
        check("tr3_fail", train_fail_o, 1);
        step(1);
        check("tr3_fail_cleared", train_fail_o, 0);

        // Async reset mid-sweep at tap 7.
        pass_mask = 16'hFFFF;
        send(1'b0, 1'b1, 4'd0);
        begin
            int k = 0;
            while (!(delay_rx_o === 4'd7 && probe_req_o === 1'b1) && k < 1000) begin
                step(1);
                k++;
            end
            check("rst_sweep_reached_tap7", delay_rx_o, 7);
        end
        #2 rst_ni = 1'b0;
        #1;
        check("arst_rx", delay_rx_o, 8);
        check("arst_tx", delay_tx_o, 8);
        check("arst_probe", probe_req_o, 0);
        check("arst_ready", cfg_ready_o, 1);
        step(1);
        rst_ni = 1'b1;
        step(1);
        send(1'b0, 1'b0, 4'd10);
        wait_done("post_rst_done", 50);
        check("post_rst_rx", delay_rx_o, 10);
        check("post_rst_result", result_o, 10);
        check("post_rst_tx", delay_tx_o, 8);
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
